// File: rtl/ula_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module   : ula_multiciclo
//  Purpose  : Execute-stage ALU. Logic/arith/compare/shift codes complete
//             combinationally; mul/div/rem run on a 32-iteration shift-add /
//             restoring-divide engine and hold busy high while in flight.
//  Ports    : clock, reset (async, active-high)
//             ULActl[4:0] operation code, A[31:0], B[31:0] operands
//             start       request strobe for mul/div/rem
//             result[31:0], zero (result==0), busy (stall), done (1-cycle)
//  Revision : 1.0 - initial release
// ============================================================================
module ula_multiciclo (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  ULActl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  output logic [31:0] result,
  output logic        zero,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SRL  = 5'b00011;
  localparam logic [4:0] OP_MUL  = 5'b00100;
  localparam logic [4:0] OP_DIV  = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_LUI  = 5'b01000;
  localparam logic [4:0] OP_REM  = 5'b01001;
  localparam logic [4:0] OP_SGT  = 5'b01010;
  localparam logic [4:0] OP_SGTE = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;
  localparam logic [4:0] OP_SEQ  = 5'b01101;
  localparam logic [4:0] OP_SLL  = 5'b01110;
  localparam logic [4:0] OP_SNEQ = 5'b01111;
  localparam logic [4:0] OP_SLTE = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] mdres_q, mdres_d;
  // Shared engine registers.
  //   mul: x = accumulator, y = multiplier (shifts right), z = multiplicand (shifts left)
  //   div: x = partial remainder, y = dividend shifting out / quotient shifting in,
  //        z = divisor magnitude
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [31:0] z_q, z_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;

  logic        is_multi;
  logic        is_divrem;
  logic [31:0] comb_res;
  logic [31:0] a_mag, b_mag;
  logic [31:0] x_new, y_new, z_new;
  logic [31:0] div_part;
  logic        div_bit;
  logic [31:0] final_res;

  assign is_multi  = (ULActl == OP_MUL) || (ULActl == OP_DIV) || (ULActl == OP_REM);
  assign is_divrem = (ULActl == OP_DIV) || (ULActl == OP_REM);
  assign a_mag     = A[31] ? (~A + 32'd1) : A;
  assign b_mag     = B[31] ? (~B + 32'd1) : B;

  // Single-cycle datapath.
  always_comb begin
    comb_res = 32'd0;
    case (ULActl)
      OP_AND:  comb_res = A & B;
      OP_OR:   comb_res = A | B;
      OP_ADD:  comb_res = A + B;
      OP_SUB:  comb_res = A - B;
      OP_SRL:  comb_res = A >> B[4:0];
      OP_SLL:  comb_res = A << B[4:0];
      OP_LUI:  comb_res = B << 16;
      OP_NOT:  comb_res = ~A;
      OP_SLT:  comb_res = {31'd0, $signed(A) <  $signed(B)};
      OP_SLTE: comb_res = {31'd0, $signed(A) <= $signed(B)};
      OP_SGT:  comb_res = {31'd0, $signed(A) >  $signed(B)};
      OP_SGTE: comb_res = {31'd0, $signed(A) >= $signed(B)};
      OP_SEQ:  comb_res = {31'd0, A == B};
      OP_SNEQ: comb_res = {31'd0, A != B};
      default: comb_res = 32'd0;
    endcase
  end

  // One engine iteration. The partial remainder is always below the divisor
  // (at most 2^31), so shifting in one dividend bit still fits in 32 bits.
  always_comb begin
    x_new     = x_q;
    y_new     = y_q;
    z_new     = z_q;
    div_part  = {x_q[30:0], y_q[31]};
    div_bit   = 1'b0;
    final_res = 32'd0;
    if (op_q == OP_MUL) begin
      x_new     = x_q + (y_q[0] ? z_q : 32'd0);
      y_new     = y_q >> 1;
      z_new     = z_q << 1;
      final_res = x_new;
    end else begin
      if (div_part >= z_q) begin
        x_new   = div_part - z_q;
        div_bit = 1'b1;
      end else begin
        x_new   = div_part;
      end
      y_new = {y_q[30:0], div_bit};
      if (op_q == OP_DIV)
        final_res = q_neg_q ? (~y_new + 32'd1) : y_new;
      else
        final_res = r_neg_q ? (~x_new + 32'd1) : x_new;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    mdres_d = mdres_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    case (state_q)
      ST_IDLE: begin
        if (start && is_multi) begin
          if (is_divrem && (B == 32'd0)) begin
            state_d = ST_DONE;
            mdres_d = (ULActl == OP_DIV) ? 32'hFFFF_FFFF : A;
          end else begin
            state_d = ST_RUN;
            cnt_d   = 5'd0;
            op_d    = ULActl;
            x_d     = 32'd0;
            q_neg_d = A[31] ^ B[31];
            r_neg_d = A[31];
            if (ULActl == OP_MUL) begin
              y_d = B;
              z_d = A;
            end else begin
              y_d = a_mag;
              z_d = b_mag;
            end
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 5'd1;
        x_d   = x_new;
        y_d   = y_new;
        z_d   = z_new;
        if (cnt_q == 5'd31) begin
          state_d = ST_DONE;
          mdres_d = final_res;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 5'd0;
      mdres_q <= 32'd0;
      x_q     <= 32'd0;
      y_q     <= 32'd0;
      z_q     <= 32'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      mdres_q <= mdres_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  // Outputs. busy is combinational so the stall lands in the request cycle.
  always_comb begin
    result = 32'd0;
    case (state_q)
      ST_IDLE: result = is_multi ? mdres_q : comb_res;
      ST_RUN:  result = 32'd0;
      ST_DONE: result = mdres_q;
      default: result = 32'd0;
    endcase
  end

  assign zero = (result == 32'd0);
  assign busy = ((state_q == ST_IDLE) && start && is_multi) || (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ula_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ula_multiciclo
//  Purpose  : Self-checking bench for ula_multiciclo. Expected multi-cycle
//             results go to a scoreboard queue at request time and are popped
//             when done pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ula_multiciclo;

  logic        clock;
  logic        reset;
  logic [4:0]  ULActl;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic        done;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  ula_multiciclo dut (
    .clock  (clock),
    .reset  (reset),
    .ULActl (ULActl),
    .A      (A),
    .B      (B),
    .start  (start),
    .result (result),
    .zero   (zero),
    .busy   (busy),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive a request at a negedge (cycle 0) and record its expected result.
  task automatic issue(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    @(negedge clock);
    ULActl = op; A = a; B = b; start = 1'b1;
    exp_q.push_back(exp);
    #1;
  endtask

  // Measurement only: counts cycles from request to done (bounded) and
  // records whether busy stayed high in every cycle before done.
  task automatic wait_done(output int cycles, output logic busy_all);
    cycles   = 0;
    busy_all = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    forever begin
      @(negedge clock);
      cycles++;
      if (done) break;
      if (!busy) busy_all = 1'b0;
      if (cycles >= 100) break;
    end
  endtask

  task automatic test_reset();
    ULActl = 5'b00100; A = 32'd0; B = 32'd0; start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_mdres got=%h exp=0", result); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_comb();
    logic [4:0]  ops  [16] = '{5'b00010, 5'b00110, 5'b00111, 5'b01010, 5'b01111,
                               5'b01110, 5'b00011, 5'b01000, 5'b11111, 5'b00000,
                               5'b00001, 5'b01100, 5'b01101, 5'b10000, 5'b01011,
                               5'b10000};
    logic [31:0] as   [16] = '{32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFF0,
                               32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'h0,
                               32'hDEADBEEF, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'h0000FFFF,
                               32'd9, 32'd9, 32'hFFFFFFFF, 32'd10};
    logic [31:0] bs   [16] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd4, 32'd4,
                               32'h1234, 32'd1, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'd0,
                               32'd9, 32'd9, 32'd0, 32'd9};
    logic [31:0] exps [16] = '{32'hFFFFFFF5, 32'hFFFFFFEB, 32'd1, 32'd0, 32'd1,
                               32'hFFFFFF00, 32'h0FFFFFFF, 32'h12340000, 32'd0,
                               32'h00F0_000F, 32'hFFF0_0FFF, 32'hFFFF0000, 32'd1,
                               32'd1, 32'd0, 32'd0};
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      ULActl = ops[i]; A = as[i]; B = bs[i]; start = (i == 5);
      #1;
      checks++;
      if (result !== exps[i]) begin
        failures++;
        $display("FAIL comb[%0d] op=%b got=%h exp=%h", i, ops[i], result, exps[i]);
      end
      checks++;
      if (zero !== (exps[i] == 32'd0)) begin
        failures++;
        $display("FAIL comb_zero[%0d] got=%b exp=%b", i, zero, exps[i] == 32'd0);
      end
      if (i == 5) begin
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL comb_start_busy got=%b exp=0", busy); end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_mul();
    int cycles; logic busy_all; logic [31:0] e;
    issue(5'b00100, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mul_busy_c0 got=%b exp=1", busy); end
    wait_done(cycles, busy_all);
    e = exp_q.pop_front();
    checks++; if (cycles !== 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", cycles); end
    checks++; if (busy_all !== 1'b1) begin failures++; $display("FAIL mul_busy_run got=%b exp=1", busy_all); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mul_busy_done got=%b exp=0", busy); end
    checks++; if (result !== e) begin failures++; $display("FAIL mul_result got=%h exp=%h", result, e); end
    @(negedge clock);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mul_done_pulse got=%b exp=0", done); end
    checks++; if (result !== e) begin failures++; $display("FAIL mul_mdres_hold got=%h exp=%h", result, e); end
  endtask

  task automatic test_div();
    logic [4:0]  ops  [5] = '{5'b00101, 5'b01001, 5'b00101, 5'b01001, 5'b00101};
    logic [31:0] as   [5] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000, 32'd100};
    logic [31:0] bs   [5] = '{32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    logic [31:0] exps [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd0, 32'hFFFFFFF2};
    int cycles; logic busy_all; logic [31:0] e;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i], exps[i]);
      wait_done(cycles, busy_all);
      e = exp_q.pop_front();
      checks++; if (cycles !== 33) begin failures++; $display("FAIL div_latency[%0d] got=%0d exp=33", i, cycles); end
      checks++; if (result !== e) begin failures++; $display("FAIL div_result[%0d] got=%h exp=%h", i, result, e); end
    end
  endtask

  task automatic test_divzero();
    logic [4:0]  ops  [2] = '{5'b00101, 5'b01001};
    logic [31:0] exps [2] = '{32'hFFFFFFFF, 32'h00000055};
    int cycles; logic busy_all; logic [31:0] e;
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], 32'h55, 32'd0, exps[i]);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL dz_busy_c0[%0d] got=%b exp=1", i, busy); end
      wait_done(cycles, busy_all);
      e = exp_q.pop_front();
      checks++; if (cycles !== 1) begin failures++; $display("FAIL dz_latency[%0d] got=%0d exp=1", i, cycles); end
      checks++; if (result !== e) begin failures++; $display("FAIL dz_result[%0d] got=%h exp=%h", i, result, e); end
    end
  endtask

  task automatic test_robust();
    int cycles; logic [31:0] e;
    issue(5'b00100, 32'd1000, 32'd3, 32'd3000);
    @(posedge clock);
    #1 start = 1'b0;
    cycles = 0;
    forever begin
      @(negedge clock);
      cycles++;
      if (cycles == 5) begin
        ULActl = 5'b00101; A = 32'd77; B = 32'd0; start = 1'b1;
        #1;
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL rob_run_result got=%h exp=0", result); end
        @(posedge clock);
        #1 start = 1'b0;
        ULActl = 5'b00010;
      end else if (done || cycles >= 100) begin
        break;
      end
    end
    e = exp_q.pop_front();
    checks++; if (cycles !== 33) begin failures++; $display("FAIL rob_latency got=%0d exp=33", cycles); end
    checks++; if (result !== e) begin failures++; $display("FAIL rob_result got=%h exp=%h", result, e); end
  endtask

  task automatic test_reset_midrun();
    int cycles; logic busy_all; logic [31:0] e; logic saw_done;
    issue(5'b00100, 32'd123, 32'd456, 32'd0);
    void'(exp_q.pop_back());  // abandoned by reset, never completes
    @(posedge clock);
    #1 start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_run_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_run_done got=%b exp=0", done); end
    checks++; if (result !== 32'd0) begin failures++; $display("FAIL rst_run_mdres got=%h exp=0", result); end
    @(negedge clock);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL rst_no_done got=%b exp=0", saw_done); end
    issue(5'b00100, 32'd6, 32'd7, 32'd42);
    wait_done(cycles, busy_all);
    e = exp_q.pop_front();
    checks++; if (cycles !== 33) begin failures++; $display("FAIL rst_mul_latency got=%0d exp=33", cycles); end
    checks++; if (result !== e) begin failures++; $display("FAIL rst_mul_result got=%h exp=%h", result, e); end
  endtask

  task automatic test_back_to_back();
    int cycles; logic busy_all; logic [31:0] e;
    issue(5'b00100, 32'd2, 32'd3, 32'd6);
    wait_done(cycles, busy_all);
    e = exp_q.pop_front();
    checks++; if (result !== e) begin failures++; $display("FAIL b2b_first got=%h exp=%h", result, e); end
    // Request raised in the DONE cycle; it must only be taken one cycle later.
    ULActl = 5'b00100; A = 32'd5; B = 32'd5; start = 1'b1;
    exp_q.push_back(32'd25);
    @(negedge clock);
    checks++; if (result !== 32'd6) begin failures++; $display("FAIL b2b_not_in_done got=%h exp=%h", result, 32'd6); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    wait_done(cycles, busy_all);
    e = exp_q.pop_front();
    checks++; if (cycles !== 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", cycles); end
    checks++; if (result !== e) begin failures++; $display("FAIL b2b_second got=%h exp=%h", result, e); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    start = 1'b0;
    ULActl = 5'd0;
    A = 32'd0;
    B = 32'd0;
    test_reset();
    test_comb();
    test_mul();
    test_div();
    test_divzero();
    test_robust();
    test_reset_midrun();
    test_back_to_back();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
